lane_serializer: RTL and testbench
==================================

Name: lane_serializer

Overview:
- Inverse of the packed-vector reduction path: accepts one packed vector of LANES x WIDTH-bit operands over a valid/ready handshake.
- Emits the lanes one per cycle on a narrow valid/ready stream, lane 0 (bits [WIDTH-1:0]) first, with lane index and last flag.
- Sits between the wide operand buffers and the per-PE operand injection of the systolic array.

Parameters:
- LANES, 12, number of lanes per packed vector (>=2).
- WIDTH, 8, bits per lane.
- IDXW, 4, width of lane index output; must satisfy 2^IDXW >= LANES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  packed vector valid.
- in_ready  output  1  serializer can accept a vector this cycle.
- in_data  input  LANES*WIDTH  packed vector; lane k = in_data[WIDTH*(k+1)-1 : WIDTH*k].
- out_valid  output  1  out_data/out_idx/out_last valid.
- out_ready  input  1  downstream accepts current beat.
- out_data  output  WIDTH  current lane value.
- out_idx  output  IDXW  lane number of current beat.
- out_last  output  1  final beat of the current vector.

Behaviour:
- Reset (async, rst=1): state IDLE; out_valid=0, out_data=0, out_idx=0, out_last=0, in_ready=1, internal vector register and lane counter cleared. Reset mid-vector discards remaining lanes; no beat is emitted after reset deasserts until a new vector is accepted.
- States: IDLE, STREAM.
- IDLE: in_ready=1. On in_valid: capture in_data, go STREAM. out_valid=1 next cycle with lane 0 (latency 1 cycle from accept to first beat).
- STREAM: out_valid=1. Outputs are registered and held stable while out_valid=1 and out_ready=0; no change in data, idx or last.
- On beat handshake (out_valid & out_ready) with out_last=0: advance to next lane next cycle.
- out_last=1 on lane LANES-1 (without the optional feature).
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). This is combinational on out_ready.
- Last-beat handshake with in_valid=1 in the same cycle: capture the new vector and emit its first lane the next cycle, staying in STREAM. This gives back-to-back vectors with zero bubbles: LANES beats per LANES cycles under continuous ready.
- Last-beat handshake without in_valid: return to IDLE; out_valid=0 next cycle.
- in_data is ignored whenever in_ready=0. The vector register is loaded only on the in_valid & in_ready handshake.
- No arithmetic is performed: out_data equals the captured lane bits exactly.
- Lane counter wraps only via reload; it never exceeds LANES-1.

Optional Feature:
- Macro: LANE_SERIALIZER_SKIP_ZERO_EN.
- Defined: lanes whose value is 0 are not emitted.
  - A zero-lane mask is computed at capture.
  - Each beat jumps to the next nonzero lane in one cycle; there are no idle cycles between emitted beats.
  - out_idx reports the true lane number.
  - out_last=1 on the highest-index nonzero lane.
  - All-zero vector: exactly one beat with out_data=0, out_idx=LANES-1, out_last=1.
- Undefined: all LANES lanes are emitted in order; the mask logic is absent.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1; assert rst mid-stream after lane 3 -> out_valid=0 the next cycle and no further beats until a new vector is sent.
- Vector lanes 0..11 = 0x01..0x0C, out_ready=1 -> 12 beats on consecutive cycles, data 0x01..0x0C, idx 0..11, out_last only on idx 11, first beat 1 cycle after accept.
- Same vector with out_ready toggling 1,0,0,1 repeating -> beats held stable while stalled; sequence and values are unchanged; in_ready=0 until the last handshake.
- Two vectors (0x01..0x0C then 0xF0..0xFB) with in_valid held high and out_ready=1 -> 24 consecutive beats with no gap; second vector accepted in the cycle of idx 11 of the first.
- SKIP_ZERO_EN: lanes {0x00,0x05,0x00,0x00,0x07, remaining zeros} -> beats (0x05, idx1, last=0), (0x07, idx4, last=1); all-zero vector -> single beat (0x00, idx 11, last=1).
- in_valid pulsed with garbage while in_ready=0 mid-stream -> ignored; the current vector completes unchanged.

Source files
------------

// File: rtl/lane_serializer.sv
// Serializes a packed LANES x WIDTH vector into one lane per beat with index and last flag.
// Optional zero-lane skipping is enabled by defining LANE_SERIALIZER_SKIP_ZERO_EN.
module lane_serializer #(
   parameter int LANES = 12,
   parameter int WIDTH = 8,
   parameter int IDXW  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*WIDTH-1:0] in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic [IDXW-1:0]        out_idx,
   output logic                   out_last
);

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   state_t                       r_state, w_state_nxt;
   logic [LANES-1:0][WIDTH-1:0]  w_in_lanes, r_vec;
   logic [WIDTH-1:0]             r_data;
   logic [IDXW-1:0]              r_idx;
   logic                         r_last;
   logic                         w_stream, w_beat, w_accept, w_adv;
   logic [IDXW-1:0]              w_first_idx, w_next_idx;
   logic                         w_first_last, w_next_last;

   assign w_in_lanes = in_data;
   assign w_stream   = (r_state == S_STREAM);
   assign w_beat     = w_stream & out_ready;
   assign w_accept   = in_valid & in_ready;
   assign w_adv      = w_beat & ~r_last;

`ifdef LANE_SERIALIZER_SKIP_ZERO_EN
   logic [LANES-1:0] w_nz_in, r_nz;

   always_comb begin
      w_nz_in = '0;
      for (int k = 0; k < LANES; k++) w_nz_in[k] = |w_in_lanes[k];
   end

   // An all-zero vector falls through to a single beat on the top lane.
   always_comb begin
      w_first_idx  = IDXW'(LANES-1);
      w_first_last = 1'b1;
      for (int k = LANES-1; k >= 0; k--)
         if (w_nz_in[k]) w_first_idx = IDXW'(k);
      for (int k = 0; k < LANES; k++)
         if (w_nz_in[k] && (k > int'(w_first_idx))) w_first_last = 1'b0;
   end

   always_comb begin
      w_next_idx  = IDXW'(LANES-1);
      w_next_last = 1'b1;
      for (int k = LANES-1; k >= 0; k--)
         if (r_nz[k] && (k > int'(r_idx))) w_next_idx = IDXW'(k);
      for (int k = 0; k < LANES; k++)
         if (r_nz[k] && (k > int'(w_next_idx))) w_next_last = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_nz <= '0;
      else if (w_accept) r_nz <= w_nz_in;
   end
`else
   assign w_first_idx  = '0;
   assign w_first_last = 1'b0;
   assign w_next_idx   = r_idx + IDXW'(1);
   assign w_next_last  = (w_next_idx == IDXW'(LANES-1));
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (in_valid) w_state_nxt = S_STREAM;
         S_STREAM: if (w_beat && r_last && !in_valid) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // in_ready opens on the last handshake so a waiting vector follows with no bubble.
   always_comb begin
      out_valid = w_stream;
      in_ready  = (r_state == S_IDLE) | (w_beat & r_last);
      out_data  = r_data;
      out_idx   = r_idx;
      out_last  = r_last;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vec  <= '0;
         r_data <= '0;
         r_idx  <= '0;
         r_last <= 1'b0;
      end else if (w_accept) begin
         r_vec  <= w_in_lanes;
         r_idx  <= w_first_idx;
         r_data <= w_in_lanes[w_first_idx];
         r_last <= w_first_last;
      end else if (w_adv) begin
         r_idx  <= w_next_idx;
         r_data <= r_vec[w_next_idx];
         r_last <= w_next_last;
      end
   end

endmodule

// File: tb/tb_lane_serializer.sv
// Directed table-driven bench for lane_serializer: streaming, stalls, back-to-back, reset, skip-zero.
module tb_lane_serializer;
   localparam int LANES = 12;
   localparam int WIDTH = 8;
   localparam int IDXW  = 4;
   localparam int VW    = LANES*WIDTH;

   logic            clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic [VW-1:0]   in_data = '0;
   logic            in_ready, out_valid, out_last;
   logic [WIDTH-1:0] out_data;
   logic [IDXW-1:0] out_idx;

   int checks = 0, failures = 0;

   lane_serializer #(.LANES(LANES), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .out_last(out_last)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic            rdy;
      logic            ival;
      logic [VW-1:0]   idata;
      logic            ev;
      logic [WIDTH-1:0] ed;
      logic [IDXW-1:0] ei;
      logic            el;
      logic            eir;
   } rec_t;

   rec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [VW-1:0] ramp(input int base);
      logic [VW-1:0] v;
      v = '0;
      for (int k = 0; k < LANES; k++) v[k*WIDTH +: WIDTH] = WIDTH'(base + k);
      return v;
   endfunction

   function automatic logic [VW-1:0] garbage();
      return {$urandom, $urandom, $urandom};
   endfunction

   task automatic push_idle(input logic rdy, input logic ival, input logic [VW-1:0] d);
      rec_t r;
      r.rdy = rdy; r.ival = ival; r.idata = d;
      r.ev = 1'b0; r.ed = '0; r.ei = '0; r.el = 1'b0; r.eir = 1'b1;
      tbl.push_back(r);
   endtask

   task automatic push_beat(input logic rdy, input logic ival, input logic [VW-1:0] d,
                            input int ed, input int ei, input logic el, input logic eir);
      rec_t r;
      r.rdy = rdy; r.ival = ival; r.idata = d;
      r.ev = 1'b1; r.ed = WIDTH'(ed); r.ei = IDXW'(ei); r.el = el; r.eir = eir;
      tbl.push_back(r);
   endtask

   // Inputs change on the falling edge; outputs are sampled 1ns later.
   task automatic run_table(input string tag);
      foreach (tbl[n]) begin
         @(negedge clk);
         out_ready = tbl[n].rdy;
         in_valid  = tbl[n].ival;
         in_data   = tbl[n].idata;
         #1;
         chk($sformatf("%s[%0d].valid", tag, n), 32'(out_valid), 32'(tbl[n].ev));
         chk($sformatf("%s[%0d].in_ready", tag, n), 32'(in_ready), 32'(tbl[n].eir));
         if (tbl[n].ev) begin
            chk($sformatf("%s[%0d].data", tag, n), 32'(out_data), 32'(tbl[n].ed));
            chk($sformatf("%s[%0d].idx", tag, n), 32'(out_idx), 32'(tbl[n].ei));
            chk($sformatf("%s[%0d].last", tag, n), 32'(out_last), 32'(tbl[n].el));
         end
      end
      tbl.delete();
      in_valid = 1'b0;
   endtask

   initial begin
      logic [VW-1:0] v;
      int beat, c;
      logic rdy, eir;

      // reset state
      #1;
      chk("rst_async.valid", 32'(out_valid), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst.valid", 32'(out_valid), 32'd0);
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.data", 32'(out_data), 32'd0);
      chk("rst.idx", 32'(out_idx), 32'd0);
      chk("rst.last", 32'(out_last), 32'd0);

      // continuous ready, lanes 0x01..0x0C
      push_idle(1'b1, 1'b1, ramp(1));
      for (int k = 0; k < LANES; k++)
         push_beat(1'b1, 1'b0, '0, k + 1, k, k == LANES-1, k == LANES-1);
      push_idle(1'b1, 1'b0, '0);
      run_table("cont");

      // ready pattern 1,0,0,1 with garbage offered while in_ready is low
      push_idle(1'b0, 1'b1, ramp(1));
      beat = 0; c = 0;
      while (beat < LANES) begin
         rdy = (c % 4 == 0) || (c % 4 == 3);
         eir = rdy && (beat == LANES-1);
         push_beat(rdy, !eir, garbage(), beat + 1, beat, beat == LANES-1, eir);
         if (rdy) beat++;
         c++;
      end
      push_idle(1'b1, 1'b0, '0);
      run_table("stall");

      // back-to-back vectors, second accepted on idx 11 of the first
      push_idle(1'b1, 1'b1, ramp(1));
      for (int k = 0; k < LANES; k++)
         push_beat(1'b1, k == LANES-1, ramp(8'hF0), k + 1, k, k == LANES-1, k == LANES-1);
      for (int k = 0; k < LANES; k++)
         push_beat(1'b1, 1'b0, '0, 8'hF0 + k, k, k == LANES-1, k == LANES-1);
      push_idle(1'b1, 1'b0, '0);
      run_table("b2b");

`ifdef LANE_SERIALIZER_SKIP_ZERO_EN
      v = '0;
      v[1*WIDTH +: WIDTH] = 8'h05;
      v[4*WIDTH +: WIDTH] = 8'h07;
      push_idle(1'b1, 1'b1, v);
      push_beat(1'b1, 1'b0, '0, 8'h05, 1, 1'b0, 1'b0);
      push_beat(1'b1, 1'b0, '0, 8'h07, 4, 1'b1, 1'b1);
      push_idle(1'b1, 1'b0, '0);
      push_idle(1'b1, 1'b1, '0);
      push_beat(1'b1, 1'b0, '0, 8'h00, LANES-1, 1'b1, 1'b1);
      push_idle(1'b1, 1'b0, '0);
      run_table("skip");
`else
      v = '0;
`endif

      // reset asserted mid-vector after lane 3 handshakes
      @(negedge clk);
      in_valid = 1'b1; in_data = ramp(1); out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         chk($sformatf("mid[%0d].idx", k), 32'(out_idx), 32'(k));
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst.valid", 32'(out_valid), 32'd0);
      chk("mid_rst.in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst.data", 32'(out_data), 32'd0);
      chk("mid_rst.idx", 32'(out_idx), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("post_rst[%0d].valid", k), 32'(out_valid), 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b1; in_data = ramp(8'h20) | v;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("post_rst.first_valid", 32'(out_valid), 32'd1);
      chk("post_rst.first_data", 32'(out_data), 32'h20);
      chk("post_rst.first_idx", 32'(out_idx), 32'd0);

      repeat (LANES + 2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
